dmem_block_responder: RTL and testbench



---
 rtl/dmem_block_responder.sv | 121 ++++++++++++
 tb/tb_dmem_block_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_block_responder.sv
// Block-granular data memory behind the data cache: serves one block read or
// write per request after a fixed latency, stalling the cache via busywait.
module dmem_block_responder #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32,
    parameter int LATENCY = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] mem_address,
    input  logic [DATA_W-1:0] mem_writedata,
    output logic [DATA_W-1:0] memReaddata,
    output logic              mem_busywait
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCESS   = 2'd1,
        S_COMPLETE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        counter_q, counter_d;
    logic              op_wr_q, op_wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic req_valid_s;
    logic busy_s;
    logic access_s;

    // Simultaneous read and write is illegal and never accepted.
    assign req_valid_s = mem_read ^ mem_write;
    assign access_s    = (state_q == S_ACCESS) && (counter_q == 4'd0);

    // State and datapath registers; reset also clears the whole array.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            counter_q <= 4'd0;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            mem_q     <= mem_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_s) state_d = S_ACCESS;
                else             state_d = S_IDLE;
            end
            S_ACCESS: begin
                if (counter_q == 4'd0) state_d = S_COMPLETE;
                else                   state_d = S_ACCESS;
            end
            S_COMPLETE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Request latching, latency countdown and the single array access.
    always_comb begin
        counter_d = counter_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mem_d     = mem_q;
        if ((state_q == S_IDLE) && req_valid_s) begin
            counter_d = LAT_M1;
            op_wr_d   = mem_write;
            addr_d    = mem_address;
            wdata_d   = mem_writedata;
        end else if ((state_q == S_ACCESS) && (counter_q != 4'd0)) begin
            counter_d = counter_q - 4'd1;
        end else if (access_s) begin
            if (op_wr_q) mem_d[addr_q] = wdata_q;
            else         rdata_d = mem_q[addr_q];
        end else begin
            counter_d = counter_q;
        end
    end

    // Busywait follows the request combinationally in IDLE so the cache stalls at once.
    always_comb begin
        busy_s = 1'b0;
        case (state_q)
            S_IDLE:     busy_s = req_valid_s;
            S_ACCESS:   busy_s = 1'b1;
            S_COMPLETE: busy_s = 1'b0;
            default:    busy_s = 1'b0;
        endcase
    end

    assign mem_busywait = reset & busy_s;
    assign memReaddata  = rdata_q;

endmodule

// File: tb/tb_dmem_block_responder.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// timestamp-based transaction model of the block memory.
module tb_dmem_block_responder;

    localparam int LAT = 5;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [5:0]  mem_address = 6'h00;
    logic [31:0] mem_writedata = 32'h0;
    logic [31:0] memReaddata;
    logic        mem_busywait;

    int tests = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    // Model: edge count, in-flight request timestamp, last completion edge.
    int          cyc;
    bit          act;
    int          acc_edge;
    int          last_done;
    bit          m_wr;
    logic [5:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] marr [64];
    logic [31:0] mrd;

    dmem_block_responder #(.ADDR_W(6), .DATA_W(32), .LATENCY(LAT)) dut (
        .clock(clock), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_address(mem_address), .mem_writedata(mem_writedata),
        .memReaddata(memReaddata), .mem_busywait(mem_busywait)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        cyc = 0; act = 1'b0; acc_edge = 0; last_done = -100;
        mrd = 32'h0;
        for (int i = 0; i < 64; i++) marr[i] = 32'h0;
    endtask

    task automatic model_edge();
        cyc++;
        if (act) begin
            if (cyc == acc_edge + LAT) begin
                if (m_wr) marr[m_addr] = m_data;
                else      mrd = marr[m_addr];
                act = 1'b0;
                last_done = cyc;
            end
        end else if (cyc != last_done + 1 && (mem_read ^ mem_write)) begin
            act = 1'b1; acc_edge = cyc;
            m_wr = mem_write; m_addr = mem_address; m_data = mem_writedata;
        end
    endtask

    function automatic logic exp_busy();
        if (act)                   return 1'b1;
        else if (cyc == last_done) return 1'b0;
        else                       return mem_read ^ mem_write;
    endfunction

    task automatic tick();
        @(posedge clock);
        if (reset) model_edge();
        #1;
    endtask

    // Issue a request and hold it until busywait falls; lat = edges after acceptance.
    task automatic req(input logic r, input logic w, input logic [5:0] a,
                       input logic [31:0] d, output int lat);
        int edges = 0;
        mem_read = r; mem_write = w; mem_address = a; mem_writedata = d;
        #1;
        for (int k = 0; k < 40; k++) begin
            if (!mem_busywait) break;
            edges++;
            tick();
        end
        if (mem_busywait) chk("req_timeout", 32'd1, 32'd0);
        lat = edges - 1;
    endtask

    task automatic idle();
        mem_read = 1'b0; mem_write = 1'b0;
        tick();
    endtask

    always @(negedge clock) begin
        if (run_cmp && reset) begin
            chk("busywait", {31'd0, mem_busywait}, {31'd0, exp_busy()});
            chk("readdata", memReaddata, mrd);
            chk("no_x", {31'd0, $isunknown({memReaddata, mem_busywait})}, 32'd0);
        end
    end

    initial begin
        int lat;
        model_reset();
        // Test 1: reset pulse, then read of a cleared word.
        repeat (2) @(posedge clock);
        #1;
        chk("rst_busy", {31'd0, mem_busywait}, 32'd0);
        chk("rst_rdata", memReaddata, 32'h0);
        reset = 1'b1;
        run_cmp = 1'b1;
        req(1'b1, 1'b0, 6'h00, 32'h0, lat);
        chk("t1_lat", lat, 32'd5);
        chk("t1_rdata", memReaddata, 32'h0);
        idle();

        // Test 2: write then read back.
        req(1'b0, 1'b1, 6'h2A, 32'hDEADBEEF, lat);
        chk("t2_wr_lat", lat, 32'd5);
        idle();
        req(1'b1, 1'b0, 6'h2A, 32'h0, lat);
        chk("t2_rd_lat", lat, 32'd5);
        chk("t2_rdata", memReaddata, 32'hDEADBEEF);
        idle();
        req(1'b0, 1'b1, 6'h30, 32'h0BADF00D, lat);
        idle();

        // Test 3: inputs changing during ACCESS are ignored.
        mem_write = 1'b1; mem_address = 6'h05; mem_writedata = 32'h11223344;
        #1;
        tick();
        mem_address = 6'h06; mem_writedata = 32'h0;
        for (int k = 0; k < 40 && mem_busywait; k++) tick();
        chk("t3_done", {31'd0, mem_busywait}, 32'd0);
        idle();
        req(1'b1, 1'b0, 6'h05, 32'h0, lat);
        chk("t3_rd5", memReaddata, 32'h11223344);
        idle();
        req(1'b1, 1'b0, 6'h06, 32'h0, lat);
        chk("t3_rd6", memReaddata, 32'h0);
        idle();

        // Test 4: write-back held through COMPLETE, then fetch.
        req(1'b0, 1'b1, 6'h10, 32'hA5A5A5A5, lat);
        chk("t4_complete_busy", {31'd0, mem_busywait}, 32'd0);
        tick();
        req(1'b1, 1'b0, 6'h30, 32'h0, lat);
        chk("t4_fetch_lat", lat, 32'd5);
        chk("t4_fetch", memReaddata, 32'h0BADF00D);
        idle();
        req(1'b1, 1'b0, 6'h10, 32'h0, lat);
        chk("t4_wb", memReaddata, 32'hA5A5A5A5);
        idle();

        // Test 5: illegal read+write is never accepted.
        mem_read = 1'b1; mem_write = 1'b1; mem_address = 6'h2A; mem_writedata = 32'h12345678;
        repeat (10) tick();
        chk("t5_busy", {31'd0, mem_busywait}, 32'd0);
        chk("t5_rdata", memReaddata, 32'hA5A5A5A5);
        idle();
        req(1'b1, 1'b0, 6'h2A, 32'h0, lat);
        chk("t5_array", memReaddata, 32'hDEADBEEF);
        idle();

        // Test 6: reset mid-write aborts it and clears the array.
        mem_read = 1'b0; mem_write = 1'b1; mem_address = 6'h3F; mem_writedata = 32'hFFFFFFFF;
        #1;
        repeat (4) tick();
        reset = 1'b0;
        model_reset();
        #1;
        chk("t6_busy_drop", {31'd0, mem_busywait}, 32'd0);
        chk("t6_rdata_rst", memReaddata, 32'h0);
        mem_write = 1'b0;
        tick(); tick();
        reset = 1'b1;
        req(1'b1, 1'b0, 6'h3F, 32'h0, lat);
        chk("t6_rd3f", memReaddata, 32'h0);
        idle();
        req(1'b1, 1'b0, 6'h2A, 32'h0, lat);
        chk("t6_rd2a", memReaddata, 32'h0);
        idle();

        // Randomized traffic, including held, illegal and mid-cycle reset cases.
        for (int n = 0; n < 1500; n++) begin
            int sel = $urandom_range(0, 99);
            if (sel < 2) begin
                reset = 1'b0;
                model_reset();
                #1;
                chk("rnd_rst_busy", {31'd0, mem_busywait}, 32'd0);
                tick(); tick();
                reset = 1'b1;
            end else begin
                if (sel < 60) begin
                    mem_read = 1'($urandom_range(0, 1));
                    mem_write = 1'($urandom_range(0, 1));
                end
                if ($urandom_range(0, 3) == 0) mem_address = 6'($urandom_range(0, 63));
                else                           mem_address = 6'($urandom_range(0, 7));
                mem_writedata = $urandom;
                tick();
            end
        end

        run_cmp = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
